// File: rtl/pipe_stream_checker.sv
// Purpose: checks a streamed word sequence against a generated pattern (counter, LFSR, walking-one, constant) and reports run statistics.
// Latency: run counters update on the accepting edge; error results update one cycle after the word is accepted.
// Backpressure: none; one word per cycle may be accepted whenever data_valid is high.
module pipe_stream_checker #(
    parameter int DATA_WIDTH = 64,
    parameter int SWAP_LANES = 1,
    parameter int ERR_WIDTH  = 32
) (
    input  logic                  okClk,
    input  logic                  reset,
    input  logic                  arm,
    input  logic                  abort,
    input  logic [1:0]            mode,
    input  logic [31:0]           seed,
    input  logic [31:0]           expected_words,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  data_valid,
    output logic [1:0]            state,
    output logic                  timer_on,
    output logic [63:0]           clk_counts,
    output logic [31:0]           word_count,
    output logic [ERR_WIDTH-1:0]  error_count,
    output logic [31:0]           first_err_index,
    output logic                  first_err_valid,
    output logic                  done
);
    localparam int L  = DATA_WIDTH / 32;
    // Per-word mismatch count never exceeds 8 lanes.
    localparam int NW = 4;
    localparam int SW = ((ERR_WIDTH > NW) ? ERR_WIDTH : NW) + 1;
    localparam logic [ERR_WIDTH-1:0] ERR_MAX = {ERR_WIDTH{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_RUN   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  w_accept;
    logic                  w_last;

    logic [1:0]            r_mode;
    logic [31:0]           r_seed;
    logic [31:0]           r_expected;

    logic [31:0]           r_gen_cnt;
    logic [31:0]           r_gen_lfsr;
    logic [4:0]            r_gen_walk;
    logic [31:0]           w_lfsr_adv;
    logic [31:0]           w_exp  [L];
    logic [31:0]           w_lane [L];
    logic [NW-1:0]         w_nerr;
    logic [31:0]           v_lfsr;

    logic [63:0]           r_clk_counts;
    logic [31:0]           r_word_count;

    logic                  r_cmp_vld;
    logic [NW-1:0]         r_cmp_nerr;
    logic [31:0]           r_cmp_idx;

    logic [ERR_WIDTH-1:0]  r_error_count;
    logic [31:0]           r_first_err_index;
    logic                  r_first_err_valid;
    logic                  r_done;
    logic [SW-1:0]         w_err_sum;
    logic [ERR_WIDTH-1:0]  w_err_sat;

    function automatic logic [31:0] lfsr_step(input logic [31:0] x);
        return {x[30:0], 1'b0} ^ (x[31] ? 32'h0040_0007 : 32'h0);
    endfunction

    assign w_last = (r_expected != 32'd0) && ((r_word_count + 32'd1) == r_expected);

    // State register.
    always_ff @(posedge okClk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Next-state and word-acceptance decode; arm outranks abort and data_valid.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        if (arm) begin
            w_state_nxt = S_ARMED;
        end else begin
            case (r_state)
                S_ARMED, S_RUN: begin
                    if (abort) begin
                        w_state_nxt = S_DONE;
                    end else if (data_valid) begin
                        w_accept    = 1'b1;
                        w_state_nxt = w_last ? S_DONE : S_RUN;
                    end
                end
                default: w_state_nxt = r_state;
            endcase
        end
    end

    // Run configuration captured on arm only.
    always_ff @(posedge okClk) begin
        if (reset) begin
            r_mode     <= 2'd0;
            r_seed     <= 32'd0;
            r_expected <= 32'd0;
        end else if (arm) begin
            r_mode     <= mode;
            r_seed     <= seed;
            r_expected <= expected_words;
        end
    end

    // Pattern generators hold the value for lane 0 of the next word and advance by L lanes per accepted word.
    always_ff @(posedge okClk) begin
        if (reset) begin
            r_gen_cnt  <= 32'd0;
            r_gen_lfsr <= 32'd1;
            r_gen_walk <= 5'd0;
        end else if (arm) begin
            r_gen_cnt  <= seed;
            r_gen_lfsr <= (seed == 32'd0) ? 32'd1 : seed;
            r_gen_walk <= 5'd0;
        end else if (w_accept) begin
            r_gen_cnt  <= r_gen_cnt + 32'(L);
            r_gen_lfsr <= w_lfsr_adv;
            r_gen_walk <= r_gen_walk + 5'(L);
        end
    end

    // Per-lane expected values, lane extraction and mismatch count for the word on data_in.
    always_comb begin
        v_lfsr = r_gen_lfsr;
        w_nerr = '0;
        for (int k = 0; k < L; k++) begin
            case (r_mode)
                2'd0:    w_exp[k] = r_gen_cnt + 32'(k);
                2'd1:    w_exp[k] = v_lfsr;
                2'd2:    w_exp[k] = 32'd1 << (r_gen_walk + 5'(k));
                default: w_exp[k] = r_seed;
            endcase
            v_lfsr = lfsr_step(v_lfsr);
            if (SWAP_LANES != 0) w_lane[k] = data_in[DATA_WIDTH-1-32*k -: 32];
            else                 w_lane[k] = data_in[32*k +: 32];
            if (w_lane[k] != w_exp[k]) w_nerr = w_nerr + NW'(1);
        end
        w_lfsr_adv = v_lfsr;
    end

    // Run duration and accepted-word counters; both wrap freely.
    always_ff @(posedge okClk) begin
        if (reset || arm) begin
            r_clk_counts <= 64'd0;
            r_word_count <= 32'd0;
        end else if (r_state == S_RUN) begin
            r_clk_counts <= r_clk_counts + 64'd1;
            if (w_accept) r_word_count <= r_word_count + 32'd1;
        end else if (w_accept) begin
            r_clk_counts <= 64'd1;
            r_word_count <= 32'd1;
        end
    end

    // Compare stage: hold the mismatch count and index of the word just accepted; reset or arm drops it.
    always_ff @(posedge okClk) begin
        if (reset || arm) begin
            r_cmp_vld  <= 1'b0;
            r_cmp_nerr <= '0;
            r_cmp_idx  <= 32'd0;
        end else begin
            r_cmp_vld  <= w_accept;
            r_cmp_nerr <= w_nerr;
            r_cmp_idx  <= r_word_count;
        end
    end

    assign w_err_sum = SW'(r_error_count) + SW'(r_cmp_nerr);
    assign w_err_sat = (w_err_sum > SW'(ERR_MAX)) ? ERR_MAX : w_err_sum[ERR_WIDTH-1:0];

    // Error accumulation (saturating) and first-error capture, plus the done flag that trails DONE by one cycle.
    always_ff @(posedge okClk) begin
        if (reset || arm) begin
            r_error_count     <= '0;
            r_first_err_index <= 32'd0;
            r_first_err_valid <= 1'b0;
            r_done            <= 1'b0;
        end else begin
            if (r_cmp_vld && (r_cmp_nerr != '0)) begin
                r_error_count <= w_err_sat;
                if (!r_first_err_valid) begin
                    r_first_err_valid <= 1'b1;
                    r_first_err_index <= r_cmp_idx;
                end
            end
            if (r_state == S_DONE) r_done <= 1'b1;
        end
    end

    assign state           = r_state;
    assign timer_on        = (r_state == S_RUN);
    assign clk_counts      = r_clk_counts;
    assign word_count      = r_word_count;
    assign error_count     = r_error_count;
    assign first_err_index = r_first_err_index;
    assign first_err_valid = r_first_err_valid;
    assign done            = r_done;

endmodule

// File: tb/tb_pipe_stream_checker.sv
// Bench for pipe_stream_checker: three instances (default, 4-bit error counter, unswapped lanes) share stimulus.
// A reference model tracks state/counters every cycle; per-word error results go through a scoreboard queue.
// Inputs change 1 time unit after the rising edge, outputs are sampled at the same point.
module tb_pipe_stream_checker;
    logic        okClk = 1'b0;
    logic        rst_i, arm_i, abort_i, dv_i;
    logic [1:0]  mode_i;
    logic [31:0] seed_i, exp_i;
    logic [63:0] din_i;

    logic [1:0]  st_a, st_b, st_c;
    logic        tmr_a, tmr_b, tmr_c;
    logic [63:0] clk_a, clk_b, clk_c;
    logic [31:0] wc_a, wc_b, wc_c;
    logic [31:0] err_a, err_c;
    logic [3:0]  err_b;
    logic [31:0] fidx_a, fidx_b, fidx_c;
    logic        fvld_a, fvld_b, fvld_c;
    logic        done_a, done_b, done_c;

    always #5 okClk = ~okClk;

    pipe_stream_checker #(.DATA_WIDTH(64), .SWAP_LANES(1), .ERR_WIDTH(32)) dut_a (
        .okClk(okClk), .reset(rst_i), .arm(arm_i), .abort(abort_i), .mode(mode_i), .seed(seed_i),
        .expected_words(exp_i), .data_in(din_i), .data_valid(dv_i), .state(st_a), .timer_on(tmr_a),
        .clk_counts(clk_a), .word_count(wc_a), .error_count(err_a), .first_err_index(fidx_a),
        .first_err_valid(fvld_a), .done(done_a));

    pipe_stream_checker #(.DATA_WIDTH(64), .SWAP_LANES(1), .ERR_WIDTH(4)) dut_b (
        .okClk(okClk), .reset(rst_i), .arm(arm_i), .abort(abort_i), .mode(mode_i), .seed(seed_i),
        .expected_words(exp_i), .data_in(din_i), .data_valid(dv_i), .state(st_b), .timer_on(tmr_b),
        .clk_counts(clk_b), .word_count(wc_b), .error_count(err_b), .first_err_index(fidx_b),
        .first_err_valid(fvld_b), .done(done_b));

    pipe_stream_checker #(.DATA_WIDTH(64), .SWAP_LANES(0), .ERR_WIDTH(32)) dut_c (
        .okClk(okClk), .reset(rst_i), .arm(arm_i), .abort(abort_i), .mode(mode_i), .seed(seed_i),
        .expected_words(exp_i), .data_in(din_i), .data_valid(dv_i), .state(st_c), .timer_on(tmr_c),
        .clk_counts(clk_c), .word_count(wc_c), .error_count(err_c), .first_err_index(fidx_c),
        .first_err_valid(fvld_c), .done(done_c));

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Reference model state
    logic [1:0]  m_st, m_mode;
    logic [31:0] m_wc, m_seed, m_exp;
    logic [63:0] m_clk;
    logic        m_done;
    logic [63:0] m_err  [3];
    logic [31:0] m_fidx [3];
    logic        m_fvld [3];
    logic [63:0] m_max  [3] = '{64'hFFFF_FFFF, 64'hF, 64'hFFFF_FFFF};

    typedef struct {
        int          d;
        int          due;
        logic [63:0] err;
        logic [31:0] fidx;
        logic        fvld;
    } sb_t;
    sb_t sb_q[$];

    typedef struct {
        logic [1:0]       mode;
        logic [31:0]      seed;
        logic [31:0]      expw;
        int               nw;
        logic [9:0][63:0] w;
        int               tgt;
        logic [31:0]      e_err;
        logic [31:0]      e_fidx;
        logic             e_fvld;
        logic [31:0]      e_wc;
        logic [63:0]      e_clk;
        logic [1:0]       e_st;
    } vec_t;
    vec_t vt [6];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    function automatic logic [63:0] get_err(input int d);
        if (d == 0) return {32'd0, err_a};
        if (d == 1) return {60'd0, err_b};
        return {32'd0, err_c};
    endfunction

    function automatic logic [31:0] get_fidx(input int d);
        if (d == 0) return fidx_a;
        if (d == 1) return fidx_b;
        return fidx_c;
    endfunction

    function automatic logic get_fvld(input int d);
        if (d == 0) return fvld_a;
        if (d == 1) return fvld_b;
        return fvld_c;
    endfunction

    function automatic logic [31:0] exp_lane(input logic [1:0] md, input logic [31:0] sd, input int unsigned i);
        logic [31:0] x;
        case (md)
            2'd0: return sd + i;
            2'd1: begin
                x = (sd == 32'd0) ? 32'd1 : sd;
                for (int unsigned s = 0; s < i; s++) x = (x << 1) ^ (x[31] ? 32'h0040_0007 : 32'h0);
                return x;
            end
            2'd2: return 32'h1 << (i % 32);
            default: return sd;
        endcase
    endfunction

    function automatic logic [31:0] lane_of(input logic [63:0] w, input logic swap, input int k);
        if (swap) return (k == 0) ? w[63:32] : w[31:0];
        return (k == 0) ? w[31:0] : w[63:32];
    endfunction

    task automatic clear_results();
        for (int d = 0; d < 3; d++) begin
            m_err[d]  = 64'd0;
            m_fidx[d] = 32'd0;
            m_fvld[d] = 1'b0;
        end
        sb_q.delete();
    endtask

    // Score one accepted word for every instance; results are due one edge after the accepting edge.
    task automatic score_word(input logic [31:0] widx);
        for (int d = 0; d < 3; d++) begin
            int unsigned n;
            sb_t e;
            n = 0;
            for (int k = 0; k < 2; k++)
                if (lane_of(din_i, d != 2, k) != exp_lane(m_mode, m_seed, widx * 2 + 32'(k))) n++;
            if (n != 0) begin
                if (m_err[d] + 64'(n) > m_max[d]) m_err[d] = m_max[d];
                else m_err[d] = m_err[d] + 64'(n);
                if (!m_fvld[d]) begin
                    m_fvld[d] = 1'b1;
                    m_fidx[d] = widx;
                end
            end
            e.d = d; e.due = cyc + 2; e.err = m_err[d]; e.fidx = m_fidx[d]; e.fvld = m_fvld[d];
            sb_q.push_back(e);
        end
    endtask

    // Advance the model with the currently driven inputs, clock once, then compare.
    task automatic step();
        logic done_n;
        sb_t e;
        done_n = (m_st == 2'd3) && !arm_i && !rst_i;
        if (rst_i) begin
            m_st = 0; m_wc = 0; m_clk = 0; m_mode = 0; m_seed = 0; m_exp = 0;
            clear_results();
        end else if (arm_i) begin
            m_st = 1; m_wc = 0; m_clk = 0; m_mode = mode_i; m_seed = seed_i; m_exp = exp_i;
            clear_results();
        end else if (m_st == 2'd1 || m_st == 2'd2) begin
            if (m_st == 2'd2) m_clk = m_clk + 64'd1;
            if (abort_i) begin
                m_st = 3;
            end else if (dv_i) begin
                if (m_st == 2'd1) m_clk = 64'd1;
                score_word(m_wc);
                m_wc = m_wc + 32'd1;
                m_st = (m_exp != 0 && m_wc == m_exp) ? 2'd3 : 2'd2;
            end
        end
        m_done = done_n;
        @(posedge okClk);
        #1;
        cyc++;
        chk("state", {62'd0, st_a}, {62'd0, m_st});
        chk("word_count", {32'd0, wc_a}, {32'd0, m_wc});
        chk("clk_counts", clk_a, m_clk);
        chk("done", {63'd0, done_a}, {63'd0, m_done});
        chk("timer_on", {63'd0, tmr_a}, {63'd0, (m_st == 2'd2)});
        while (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
            e = sb_q.pop_front();
            chk($sformatf("error_count_d%0d", e.d), get_err(e.d), e.err);
            chk($sformatf("first_err_index_d%0d", e.d), {32'd0, get_fidx(e.d)}, {32'd0, e.fidx});
            chk($sformatf("first_err_valid_d%0d", e.d), {63'd0, get_fvld(e.d)}, {63'd0, e.fvld});
        end
        arm_i = 0; abort_i = 0; dv_i = 0;
    endtask

    task automatic do_arm(input logic [1:0] md, input logic [31:0] sd, input logic [31:0] ew);
        arm_i = 1; mode_i = md; seed_i = sd; exp_i = ew;
        step();
        // later changes of mode/seed must not matter
        mode_i = ~md;
        seed_i = $urandom;
    endtask

    task automatic send(input logic [63:0] w);
        dv_i = 1; din_i = w;
        step();
    endtask

    task automatic idle(input int n);
        for (int j = 0; j < n; j++) step();
    endtask

    task automatic run_vec(input vec_t v, input int id);
        do_arm(v.mode, v.seed, v.expw);
        for (int k = 0; k < v.nw; k++) send(v.w[k]);
        idle(3);
        chk($sformatf("vec%0d_err", id), get_err(v.tgt), {32'd0, v.e_err});
        chk($sformatf("vec%0d_fidx", id), {32'd0, get_fidx(v.tgt)}, {32'd0, v.e_fidx});
        chk($sformatf("vec%0d_fvld", id), {63'd0, get_fvld(v.tgt)}, {63'd0, v.e_fvld});
        chk($sformatf("vec%0d_wc", id), {32'd0, wc_a}, {32'd0, v.e_wc});
        chk($sformatf("vec%0d_clk", id), clk_a, v.e_clk);
        chk($sformatf("vec%0d_state", id), {62'd0, st_a}, {62'd0, v.e_st});
        chk($sformatf("vec%0d_done", id), {63'd0, done_a}, 64'd1);
    endtask

    initial begin
        // Directed runs: counter clean, counter one bad lane, saturation, LFSR unswapped, walking-one, counter wrap.
        vt[0] = '{mode:2'd0, seed:32'd0, expw:32'd4, nw:4, w:'0, tgt:0, e_err:0, e_fidx:0, e_fvld:0, e_wc:4, e_clk:64'd4, e_st:2'd3};
        vt[0].w[0] = 64'h00000000_00000001; vt[0].w[1] = 64'h00000002_00000003;
        vt[0].w[2] = 64'h00000004_00000005; vt[0].w[3] = 64'h00000006_00000007;
        vt[1] = vt[0];
        vt[1].w[2] = 64'h00000004_FFFFFFFF; vt[1].e_err = 1; vt[1].e_fidx = 2; vt[1].e_fvld = 1;
        vt[2] = '{mode:2'd3, seed:32'hFFFFFFFF, expw:32'd10, nw:10, w:'0, tgt:1, e_err:15, e_fidx:0, e_fvld:1, e_wc:10, e_clk:64'd10, e_st:2'd3};
        vt[3] = '{mode:2'd1, seed:32'd0, expw:32'd2, nw:2, w:'0, tgt:2, e_err:0, e_fidx:0, e_fvld:0, e_wc:2, e_clk:64'd2, e_st:2'd3};
        vt[3].w[0] = 64'h00000002_00000001; vt[3].w[1] = 64'h00000008_00000004;
        vt[4] = '{mode:2'd2, seed:32'h1234, expw:32'd3, nw:3, w:'0, tgt:0, e_err:1, e_fidx:1, e_fvld:1, e_wc:3, e_clk:64'd3, e_st:2'd3};
        vt[4].w[0] = 64'h00000001_00000002; vt[4].w[1] = 64'h00000004_00000009; vt[4].w[2] = 64'h00000010_00000020;
        vt[5] = '{mode:2'd0, seed:32'hFFFFFFFE, expw:32'd2, nw:2, w:'0, tgt:0, e_err:0, e_fidx:0, e_fvld:0, e_wc:2, e_clk:64'd2, e_st:2'd3};
        vt[5].w[0] = 64'hFFFFFFFE_FFFFFFFF; vt[5].w[1] = 64'h00000000_00000001;

        rst_i = 1; arm_i = 0; abort_i = 0; dv_i = 0; mode_i = 0; seed_i = 0; exp_i = 0; din_i = 0;
        m_st = 0; m_wc = 0; m_clk = 0; m_done = 0; m_mode = 0; m_seed = 0; m_exp = 0;
        clear_results();
        idle(2);
        rst_i = 0;
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("reset_err_d%0d", d), get_err(d), 64'd0);
            chk($sformatf("reset_fvld_d%0d", d), {63'd0, get_fvld(d)}, 64'd0);
        end

        // abort and data in IDLE are ignored
        abort_i = 1; dv_i = 1; step();
        chk("idle_abort_state", {62'd0, st_a}, 64'd0);

        for (int v = 0; v < 6; v++) run_vec(vt[v], v);

        // Unlimited run, gapped words, abort; then re-arm clears everything
        do_arm(2'd0, 32'd0, 32'd0);
        send(64'h00000000_00000001); idle(1);
        send(64'h00000002_00000003); idle(1);
        send(64'h00000004_00000005); idle(4);
        abort_i = 1; step();
        chk("abort_state", {62'd0, st_a}, 64'd3);
        chk("abort_wc", {32'd0, wc_a}, 64'd3);
        chk("abort_clk", clk_a, 64'd10);
        idle(1);
        chk("abort_done", {63'd0, done_a}, 64'd1);
        dv_i = 1; din_i = 64'h1; step();
        chk("done_frozen_wc", {32'd0, wc_a}, 64'd3);
        do_arm(2'd0, 32'd0, 32'd0);
        chk("rearm_state", {62'd0, st_a}, 64'd1);
        chk("rearm_clk", clk_a, 64'd0);
        chk("rearm_done", {63'd0, done_a}, 64'd0);

        // arm beats abort and data_valid mid-run
        send(64'h00000000_00000001);
        send(64'h00000002_00000099);
        arm_i = 1; abort_i = 1; dv_i = 1; din_i = 64'h00000004_00000005; step();
        chk("arm_wins_state", {62'd0, st_a}, 64'd1);
        chk("arm_wins_wc", {32'd0, wc_a}, 64'd0);
        chk("arm_wins_err", {32'd0, err_a}, 64'd0);
        idle(2);
        chk("arm_wins_err_late", {32'd0, err_a}, 64'd0);

        // reset the cycle after a bad word drops the pending compare
        send(64'h00000000_00000001);
        send(64'h00000002_00000099);
        rst_i = 1; step(); rst_i = 0;
        chk("rst_state", {62'd0, st_a}, 64'd0);
        chk("rst_err", {32'd0, err_a}, 64'd0);
        chk("rst_fvld", {63'd0, fvld_a}, 64'd0);
        idle(2);
        chk("rst_err_late", {32'd0, err_a}, 64'd0);
        chk("rst_fvld_late", {63'd0, fvld_a}, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/pipe_stream_checker.md
PIPE_STREAM_CHECKER -- requirements
Module: pipe_stream_checker

Interface
REQ-001 Parameter DATA_WIDTH, default 64: checked word width; SHALL be a multiple of 32, range 32..256; L = DATA_WIDTH/32 lanes.
REQ-002 Parameter SWAP_LANES, default 1: when 1, lane 0 SHALL be data_in[DATA_WIDTH-1 -: 32]; when 0, lane 0 SHALL be data_in[31:0].
REQ-003 Parameter ERR_WIDTH, default 32: error counter width.
REQ-004 okClk  in  1  sole clock; all logic on its rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 arm  in  1  one-cycle pulse; clear results, enter ARMED.
REQ-007 abort  in  1  one-cycle pulse; end run early.
REQ-008 mode  in  2  pattern: 0 counter, 1 LFSR, 2 walking-one, 3 constant.
REQ-009 seed  in  32  pattern seed; sampled on arm.
REQ-010 expected_words  in  32  run length in words, sampled on arm; 0 = unlimited.
REQ-011 data_in  in  DATA_WIDTH  word under test.
REQ-012 data_valid  in  1  data_in valid this cycle.
REQ-013 state  out  2  0 IDLE, 1 ARMED, 2 RUN, 3 DONE.
REQ-014 timer_on  out  1  high while state = RUN.
REQ-015 clk_counts  out  64  run duration in okClk cycles.
REQ-016 word_count  out  32  words accepted this run.
REQ-017 error_count  out  ERR_WIDTH  mismatching lanes, saturating.
REQ-018 first_err_index / first_err_valid  out  32 / 1  0-based word index of first mismatching word; valid flag.
REQ-019 done  out  1  results final.

Function
REQ-020 Word n, lane k expected value, with i = n*L+k: mode 0: seed+i mod 2^32; mode 1: LFSR state after i steps, step x -> (x<<1) ^ (x[31] ? 32'h00400007 : 0), start = seed, or 1 if seed = 0; mode 2: 1 << (i mod 32); mode 3: seed.
REQ-021 mode and seed SHALL be latched on arm; changes at other times SHALL have no effect until next arm.
REQ-022 IDLE: data_valid ignored; arm -> ARMED.
REQ-023 ARMED: first data_valid -> RUN; that word accepted as word 0; clk_counts = 1 after that edge.
REQ-024 RUN: clk_counts +1 every cycle; each data_valid accepts one word, word_count +1.
REQ-025 RUN: accepting word with word_count+1 = expected_words (nonzero) -> DONE on that edge; clk_counts includes that cycle.
REQ-026 abort in ARMED or RUN -> DONE; abort in IDLE or DONE ignored.
REQ-027 DONE: counters frozen, data_valid ignored; arm -> ARMED.
REQ-028 arm in any state SHALL clear clk_counts, word_count, error_count, first_err_index, first_err_valid, done, and enter ARMED; arm beats abort and data_valid in the same cycle (word discarded).
REQ-029 Compare registered: error_count and first_err_* for a word SHALL update exactly 1 cycle after acceptance, including the final word after entry to DONE.
REQ-030 error_count += number of mismatching lanes in the word; SHALL saturate at all-ones, never wrap.
REQ-031 first_err_index set, first_err_valid raised, only on first mismatching word; later errors leave them unchanged.
REQ-032 done SHALL assert 1 cycle after entering DONE and stay high until arm or reset.
REQ-033 clk_counts and word_count SHALL wrap modulo 2^64 / 2^32; wrap does not end run when expected_words = 0.
REQ-034 Max throughput: one word per cycle, no back-pressure.

Reset
REQ-035 reset SHALL win over all inputs; next edge: state IDLE, all outputs 0, latched mode/seed/expected_words 0.
REQ-036 reset mid-RUN SHALL discard the in-flight compare; no error update after reset.

Verification
REQ-037 DATA_WIDTH 64, SWAP_LANES 1, mode 0, seed 0, expected 4; back-to-back 64'h00000000_00000001, 64'h00000002_00000003, 64'h00000004_00000005, 64'h00000006_00000007 -> error_count 0, word_count 4, clk_counts 4, state 3, done 1 cycle later.
REQ-038 Same, word 2 = 64'h00000004_FFFFFFFF -> error_count 1, first_err_index 2, first_err_valid 1.
REQ-039 ERR_WIDTH 4, mode 3, seed 32'hFFFFFFFF, 10 zero words -> error_count 15 (saturated), first_err_index 0.
REQ-040 mode 1, seed 0, SWAP_LANES 0: words 64'h00000002_00000001, 64'h00000008_00000004 -> error_count 0.
REQ-041 expected 0; 3 words with 2-cycle gaps, abort 5 cycles after last -> state DONE, word_count 3, clk_counts 10; then arm -> ARMED, all counts 0.
REQ-042 reset asserted 1 cycle after a mismatching word in RUN -> state IDLE, error_count 0, first_err_valid 0.
